ddr3_burst_scheduler: RTL and testbench

//   Sequencer that shares the single MIG AXI4 slave between the write channel (wrfifo -> DDR3) and
//   the read channel (DDR3 -> rdfifo). Watches FIFO fill levels in ui_clk, grants whole bursts with

---
 rtl/ddr3_burst_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_ddr3_burst_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_scheduler.sv
// ddr3_burst_scheduler
//   Shares one MIG AXI4 slave between the write path (wrfifo -> DDR3) and the
//   read path (DDR3 -> rdfifo). It watches the FIFO fill levels and grants
//   whole bursts with round-robin fairness. It also produces the byte address
//   of each burst and wraps each channel's window between BEGIN and its END
//   input. At most one burst is outstanding at a time.
//
// Ports
//   clk            ui_clk from MIG, the only clock domain
//   reset          synchronous, active-high
//   wr_addr_end    write window end byte address (exclusive), quasi-static
//   rd_addr_end    read window end byte address (exclusive), quasi-static
//   wr_fifo_beats  beats readable from wrfifo
//   rd_fifo_beats  beats stored in rdfifo
//   wr_clr/rd_clr  pulse: restart that channel's window at its BEGIN
//   wr_start       1-cycle pulse: write engine starts a burst at wr_addr
//   wr_addr        write burst byte address, stable from wr_start to wr_done
//   wr_done        1-cycle pulse from write engine: burst finished
//   rd_start       1-cycle pulse: read engine starts a burst at rd_addr
//   rd_addr        read burst byte address, stable from rd_start to rd_done
//   rd_done        1-cycle pulse from read engine: burst finished
//   busy           high while a burst is in ISSUE or WAIT
//
// State table
//   S_IDLE     | no burst outstanding, arbitrating between channels
//   S_WR_ISSUE | wr_start asserted for this single cycle
//   S_WR_WAIT  | write burst in flight, waiting for wr_done
//   S_RD_ISSUE | rd_start asserted for this single cycle
//   S_RD_WAIT  | read burst in flight, waiting for rd_done

module ddr3_burst_scheduler #(
  parameter int AXI_ADDR_WIDTH = 30,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int BURST_LEN      = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] WR_ADDR_BEGIN = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] RD_ADDR_BEGIN = '0,
  parameter int RD_FIFO_BEATS  = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [23:0]               wr_addr_end,
  input  logic [23:0]               rd_addr_end,
  input  logic [15:0]               wr_fifo_beats,
  input  logic [15:0]               rd_fifo_beats,
  input  logic                      wr_clr,
  input  logic                      rd_clr,
  output logic                      wr_start,
  output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
  input  logic                      wr_done,
  output logic                      rd_start,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_done,
  output logic                      busy
);

  localparam int BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
  // Two guard bits so addr + 2*BURST_BYTES can never overflow the compare.
  localparam int CW = AXI_ADDR_WIDTH + 2;
  localparam logic [CW-1:0] BURST_BYTES_C   = CW'(BURST_BYTES);
  localparam logic [16:0]   BURST_LEN_C     = 17'(BURST_LEN);
  localparam logic [16:0]   RD_FIFO_BEATS_C = 17'(RD_FIFO_BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT
  } state_t;

  state_t state, state_next;

  logic        last_grant_rd;   // 1: read was granted last, so write wins a tie
  logic        wr_clr_pend;
  logic        rd_clr_pend;
  logic [16:0] rd_level;
  logic [16:0] rd_free;
  logic        wr_ok;
  logic        rd_ok;
  logic        wr_in_burst;
  logic        rd_in_burst;
  logic        wr_fin;
  logic        rd_fin;

  // Next burst address: wraps to BEGIN when the following burst would cross END.
  function automatic logic [AXI_ADDR_WIDTH-1:0] advance_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [23:0]               end_addr,
    input logic [AXI_ADDR_WIDTH-1:0] begin_addr
  );
    logic [CW-1:0] nxt;
    nxt = {2'b00, addr} + BURST_BYTES_C;
    if ((nxt + BURST_BYTES_C) > CW'(end_addr))
      return begin_addr;
    else
      return nxt[AXI_ADDR_WIDTH-1:0];
  endfunction

  // An over-reported rdfifo level counts as no free space at all.
  assign rd_level = {1'b0, rd_fifo_beats};
  assign rd_free  = (rd_level > RD_FIFO_BEATS_C) ? 17'd0 : (RD_FIFO_BEATS_C - rd_level);

  assign wr_ok = ({1'b0, wr_fifo_beats} >= BURST_LEN_C) && !wr_clr;
  assign rd_ok = (rd_free >= BURST_LEN_C) && !rd_clr;

  assign wr_in_burst = (state == S_WR_ISSUE) || (state == S_WR_WAIT);
  assign rd_in_burst = (state == S_RD_ISSUE) || (state == S_RD_WAIT);
  assign wr_fin      = (state == S_WR_WAIT) && wr_done;
  assign rd_fin      = (state == S_RD_WAIT) && rd_done;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (wr_ok && (!rd_ok || last_grant_rd))
          state_next = S_WR_ISSUE;
        else if (rd_ok && (!wr_ok || !last_grant_rd))
          state_next = S_RD_ISSUE;
      end
      S_WR_ISSUE: state_next = S_WR_WAIT;
      S_WR_WAIT:  if (wr_done) state_next = S_IDLE;
      S_RD_ISSUE: state_next = S_RD_WAIT;
      S_RD_WAIT:  if (rd_done) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each start pulse lines up
  // exactly with its ISSUE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_start      <= 1'b0;
      rd_start      <= 1'b0;
      busy          <= 1'b0;
      last_grant_rd <= 1'b1;
      wr_addr       <= WR_ADDR_BEGIN;
      rd_addr       <= RD_ADDR_BEGIN;
      wr_clr_pend   <= 1'b0;
      rd_clr_pend   <= 1'b0;
    end else begin
      wr_start <= (state_next == S_WR_ISSUE);
      rd_start <= (state_next == S_RD_ISSUE);
      busy     <= (state_next != S_IDLE);

      if (state == S_WR_ISSUE)
        last_grant_rd <= 1'b0;
      else if (state == S_RD_ISSUE)
        last_grant_rd <= 1'b1;

      // A clear during the channel's own burst is deferred so the address the
      // engine is using stays stable until done.
      if (wr_fin) begin
        if (wr_clr || wr_clr_pend)
          wr_addr <= WR_ADDR_BEGIN;
        else
          wr_addr <= advance_addr(wr_addr, wr_addr_end, WR_ADDR_BEGIN);
        wr_clr_pend <= 1'b0;
      end else if (wr_clr) begin
        if (wr_in_burst)
          wr_clr_pend <= 1'b1;
        else
          wr_addr <= WR_ADDR_BEGIN;
      end

      if (rd_fin) begin
        if (rd_clr || rd_clr_pend)
          rd_addr <= RD_ADDR_BEGIN;
        else
          rd_addr <= advance_addr(rd_addr, rd_addr_end, RD_ADDR_BEGIN);
        rd_clr_pend <= 1'b0;
      end else if (rd_clr) begin
        if (rd_in_burst)
          rd_clr_pend <= 1'b1;
        else
          rd_addr <= RD_ADDR_BEGIN;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_burst_scheduler.sv
// Testbench for ddr3_burst_scheduler.
// The stimulus pushes each expected burst start ({is_read, addr}) into a queue.
// A separate monitor pops one entry per observed start and compares it.
// An engine model returns done 5 cycles after each start while auto_done is set.

module tb_ddr3_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] wr_addr_end, rd_addr_end;
  logic [15:0] wr_fifo_beats, rd_fifo_beats;
  logic        wr_clr, rd_clr;
  logic        wr_start, rd_start, busy;
  logic [29:0] wr_addr, rd_addr;
  logic        wr_done = 1'b0;
  logic        rd_done = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [30:0] exp_q[$];
  bit   auto_done   = 1'b1;
  logic man_wr_done = 1'b0;
  logic man_rd_done = 1'b0;
  bit   chk_lat     = 1'b0;
  int   cyc         = 0;
  int   last_done_cyc = -100;
  int   wc = 0;
  int   rc = 0;

  always #5 clk = ~clk;

  ddr3_burst_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .wr_addr_end   (wr_addr_end),
    .rd_addr_end   (rd_addr_end),
    .wr_fifo_beats (wr_fifo_beats),
    .rd_fifo_beats (rd_fifo_beats),
    .wr_clr        (wr_clr),
    .rd_clr        (rd_clr),
    .wr_start      (wr_start),
    .wr_addr       (wr_addr),
    .wr_done       (wr_done),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_done       (rd_done),
    .busy          (busy)
  );

  function automatic void chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Engine model: done pulses 5 cycles after the start, or on request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_done = man_wr_done;
      rd_done = man_rd_done;
      if (!auto_done || reset) begin
        wc = 0;
        rc = 0;
      end else begin
        if (wc > 0) begin
          wc--;
          if (wc == 0) wr_done = 1'b1;
        end
        if (rc > 0) begin
          rc--;
          if (rc == 0) rd_done = 1'b1;
        end
        if (wr_start) wc = 5;
        if (rd_start) rc = 5;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [30:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (wr_done || rd_done) last_done_cyc = cyc;
        if (wr_start || rd_start) begin
          chk_eq("start_onehot", 32'(wr_start & rd_start), 32'd0);
          chk_eq("busy_at_start", 32'(busy), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got wr_start=%0d rd_start=%0d wr_addr=%0d rd_addr=%0d expected no start",
                     wr_start, rd_start, wr_addr, rd_addr);
          end else begin
            e = exp_q.pop_front();
            chk_eq("start_channel_is_rd", 32'(rd_start), 32'(e[30]));
            chk_eq("start_addr", rd_start ? 32'(rd_addr) : 32'(wr_addr), 32'(e[29:0]));
            if (chk_lat) chk_eq("done_to_start_cycles", 32'(cyc - last_done_cyc), 32'd2);
          end
        end
      end
    end
  end

  task automatic push(input bit is_rd, input int addr);
    exp_q.push_back({is_rd, 30'(addr)});
  endtask

  task automatic wait_q(input int target, input int limit, input string name);
    int n = 0;
    while (exp_q.size() > target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > target) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d starts outstanding expected %0d after %0d cycles",
               name, exp_q.size(), target, limit);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy=1 expected 0 within %0d cycles", name, limit);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    wr_addr_end = 24'd2048;
    rd_addr_end = 24'd2048;
    wr_fifo_beats = 16'd0;
    rd_fifo_beats = 16'd256;
    wr_clr = 1'b0;
    rd_clr = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset values, then first write start
    chk_eq("rst_wr_start", 32'(wr_start), 32'd0);
    chk_eq("rst_rd_start", 32'(rd_start), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    wr_fifo_beats = 16'd32;
    push(1'b0, 0);
    reset = 1'b0;
    n = 0;
    while (!wr_start && n < 4) begin
      @(negedge clk);
      n++;
    end
    // Clock edges counted from the last edge that sampled reset high.
    chk_eq("reset_to_start_edges", 32'(n + 1), 32'd2);
    wr_fifo_beats = 16'd0;
    wait_q(0, 10, "t1_drain");
    wait_idle(20, "t1_idle");
    chk_eq("t1_wr_addr_after_done", 32'(wr_addr), 32'd512);

    // 2: both eligible, strict alternation starting with write
    push(1'b0, 0); push(1'b1, 0); push(1'b0, 512); push(1'b1, 512);
    wr_fifo_beats = 16'd32;
    rd_fifo_beats = 16'd0;
    reset_pulse();
    wait_q(3, 20, "t2_first");
    chk_lat = 1'b1;
    wait_q(0, 60, "t2_drain");
    wr_fifo_beats = 16'd0;
    rd_fifo_beats = 16'd256;
    chk_lat = 1'b0;
    wait_idle(20, "t2_idle");
    chk_eq("t2_wr_addr_end", 32'(wr_addr), 32'd1024);
    chk_eq("t2_rd_addr_end", 32'(rd_addr), 32'd1024);

    // 3: write window wrap at END=2048
    push(1'b0, 0); push(1'b0, 512); push(1'b0, 1024);
    push(1'b0, 1536); push(1'b0, 0); push(1'b0, 512);
    wr_fifo_beats = 16'd32;
    reset_pulse();
    wait_q(5, 20, "t3_first");
    chk_lat = 1'b1;
    wait_q(0, 80, "t3_drain");
    wr_fifo_beats = 16'd0;
    chk_lat = 1'b0;
    wait_idle(20, "t3_idle");
    chk_eq("t3_wr_addr_end", 32'(wr_addr), 32'd1024);

    // 4: wr_clr during WR_WAIT at 1024 is deferred to done
    push(1'b0, 0); push(1'b0, 512); push(1'b0, 1024);
    wr_fifo_beats = 16'd32;
    reset_pulse();
    wait_q(0, 60, "t4_drain");
    auto_done = 1'b0;
    repeat (2) @(negedge clk);
    wr_clr = 1'b1;
    @(negedge clk);
    wr_clr = 1'b0;
    repeat (10) @(negedge clk);
    chk_eq("t4_busy_held", 32'(busy), 32'd1);
    chk_eq("t4_wr_addr_held", 32'(wr_addr), 32'd1024);
    push(1'b0, 0);
    man_wr_done = 1'b1;
    @(negedge clk);
    man_wr_done = 1'b0;
    auto_done = 1'b1;
    wait_q(0, 10, "t4_after_clr");
    wr_fifo_beats = 16'd0;
    wait_idle(20, "t4_idle");
    chk_eq("t4_wr_addr_end", 32'(wr_addr), 32'd512);

    // 5: read free-space boundary
    wr_fifo_beats = 16'd31;
    rd_fifo_beats = 16'd300;
    reset_pulse();
    repeat (8) @(negedge clk);
    chk_eq("t5_no_start_overfull", 32'(busy), 32'd0);
    rd_fifo_beats = 16'd225;
    repeat (8) @(negedge clk);
    chk_eq("t5_no_start_free31", 32'(busy), 32'd0);
    push(1'b1, 0);
    rd_fifo_beats = 16'd224;
    wait_q(0, 10, "t5_free32");
    rd_fifo_beats = 16'd256;
    wr_fifo_beats = 16'd0;
    wait_idle(20, "t5_idle");
    chk_eq("t5_rd_addr_end", 32'(rd_addr), 32'd512);

    // 6: reset during RD_WAIT at 512 abandons the burst
    rd_fifo_beats = 16'd0;
    push(1'b1, 0); push(1'b1, 512);
    reset_pulse();
    wait_q(0, 30, "t6_drain");
    auto_done = 1'b0;
    rd_fifo_beats = 16'd256;
    repeat (3) @(negedge clk);
    chk_eq("t6_busy_in_wait", 32'(busy), 32'd1);
    chk_eq("t6_rd_addr_in_wait", 32'(rd_addr), 32'd512);
    reset_pulse();
    @(negedge clk);
    chk_eq("t6_rd_addr_after_reset", 32'(rd_addr), 32'd0);
    chk_eq("t6_busy_after_reset", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    chk_eq("t6_no_start_ineligible", 32'(busy), 32'd0);
    auto_done = 1'b1;
    push(1'b1, 0);
    rd_fifo_beats = 16'd0;
    wait_q(0, 10, "t6_restart");
    rd_fifo_beats = 16'd256;
    wait_idle(20, "t6_idle");
    chk_eq("t6_rd_addr_advanced", 32'(rd_addr), 32'd512);
    rd_clr = 1'b1;
    @(negedge clk);
    rd_clr = 1'b0;
    chk_eq("t6_rd_clr_idle", 32'(rd_addr), 32'd0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
